// File: rtl/nebula_vc_buffer.sv
// Multi-VC router input buffer: NUM_VCS FIFOs share one storage array, with
// per-VC pointers/counts, one-cycle read latency, credit return and sticky errors.

module nebula_vc_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_acc_i,
    input  logic             rd_acc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_acc_i && !rd_acc_i)      cnt_d = cnt_q + CNT_W'(1);
        else if (rd_acc_i && !wr_acc_i) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
endmodule

module nebula_vc_buffer #(
    parameter int DATA_WIDTH          = 32,
    parameter int NUM_VCS             = 4,
    parameter int DEPTH               = 8,
    parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESH = 2,
    localparam int VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [VC_W-1:0]          wr_vc,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [VC_W-1:0]          rd_vc,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic [VC_W-1:0]          rd_vc_out,
    output logic [NUM_VCS-1:0]       full,
    output logic [NUM_VCS-1:0]       almost_full,
    output logic [NUM_VCS-1:0]       empty,
    output logic [NUM_VCS-1:0]       almost_empty,
    output logic [NUM_VCS*CNT_W-1:0] count,
    output logic                     credit_valid,
    output logic [VC_W-1:0]          credit_vc,
    output logic                     overflow_err,
    output logic                     underflow_err,
    input  logic                     err_clr
);
    logic [NUM_VCS-1:0][CNT_W-1:0] cnt;
    logic [NUM_VCS-1:0][PTR_W-1:0] wr_ptr, rd_ptr;
    logic [NUM_VCS-1:0]            wr_sel, rd_sel;
    logic [DATA_WIDTH-1:0]         mem [NUM_VCS*DEPTH];

    logic                  wr_in_range, rd_in_range, wr_acc, rd_acc;
    logic                  rd_valid_q, ovf_q, ovf_d, unf_q, unf_d;
    logic [VC_W-1:0]       rd_vc_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    assign wr_in_range = 32'(wr_vc) < NUM_VCS;
    assign rd_in_range = 32'(rd_vc) < NUM_VCS;

    // Read is judged on the pre-write count (no bypass); a full VC still takes
    // a write when the same VC frees a slot this cycle.
    assign rd_acc = rd_en && rd_in_range && (cnt[rd_vc] != '0);
    assign wr_acc = wr_en && wr_in_range &&
                    ((cnt[wr_vc] != CNT_W'(DEPTH)) || (rd_acc && (rd_vc == wr_vc)));

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign wr_sel[v] = wr_acc && (32'(wr_vc) == v);
        assign rd_sel[v] = rd_acc && (32'(rd_vc) == v);

        nebula_vc_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_ctrl (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_acc_i (wr_sel[v]),
            .rd_acc_i (rd_sel[v]),
            .cnt_o    (cnt[v]),
            .wr_ptr_o (wr_ptr[v]),
            .rd_ptr_o (rd_ptr[v])
        );

        assign full[v]         = cnt[v] == CNT_W'(DEPTH);
        assign empty[v]        = cnt[v] == '0;
        assign almost_full[v]  = cnt[v] >= CNT_W'(ALMOST_FULL_THRESH);
        assign almost_empty[v] = cnt[v] <= CNT_W'(ALMOST_EMPTY_THRESH);
    end

    assign count = cnt;

    // Storage is not reset; read-before-write keeps the head intact when a
    // full VC is read and written on the same edge.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[{wr_vc, wr_ptr[wr_vc]}] <= wr_data;
    end

    assign ovf_d = (wr_en && !wr_acc) || (ovf_q && !err_clr);
    assign unf_d = (rd_en && !rd_acc) || (unf_q && !err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_vc_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            if (rd_acc) begin
                rd_data_q <= mem[{rd_vc, rd_ptr[rd_vc]}];
                rd_vc_q   <= rd_vc;
            end
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_vc_out     = rd_vc_q;
    assign credit_valid  = rd_valid_q;
    assign credit_vc     = rd_vc_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
endmodule

// File: tb/tb_nebula_vc_buffer.sv
// Scoreboard bench for nebula_vc_buffer: directed stimulus pushes expected
// reads, a negedge monitor pops and compares whenever rd_valid is high.

module tb_nebula_vc_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en, err_clr;
    logic [1:0]  wr_vc, rd_vc, rd_vc_out, credit_vc;
    logic [31:0] wr_data, rd_data;
    logic        rd_valid, credit_valid, overflow_err, underflow_err;
    logic [3:0]  full, almost_full, empty, almost_empty;
    logic [15:0] count;

    typedef struct {
        logic [1:0]  vc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    nebula_vc_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_vc_out(rd_vc_out),
        .full(full), .almost_full(almost_full), .empty(empty), .almost_empty(almost_empty),
        .count(count), .credit_valid(credit_valid), .credit_vc(credit_vc),
        .overflow_err(overflow_err), .underflow_err(underflow_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] cntv(input int v);
        return count[v*4 +: 4];
    endfunction

    task automatic push(input logic [1:0] vc, input logic [31:0] d);
        exp_t e;
        e.vc   = vc;
        e.data = d;
        sb.push_back(e);
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic drive(input logic we, input logic [1:0] wv, input logic [31:0] wd,
                         input logic re, input logic [1:0] rv, input logic ec);
        wr_en = we; wr_vc = wv; wr_data = wd;
        rd_en = re; rd_vc = rv; err_clr = ec;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got rd_valid vc=%0d data=%0h want none", rd_vc_out, rd_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_read", {27'd0, credit_valid, credit_vc, rd_vc_out, rd_data},
                               {27'd0, 1'b1, e.vc, e.vc, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_vc = '0; wr_data = '0;
        rd_en = 1'b0; rd_vc = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 16'h0);
        chk("rst_flags", {empty, almost_empty, full, almost_full}, 16'hFF00);
        chk("rst_rd", {rd_valid, rd_vc_out, rd_data}, 35'h0);
        chk("rst_misc", {credit_valid, credit_vc, overflow_err, underflow_err}, 5'h0);
        rst_n = 1'b1;

        // T1: single flit through VC2
        drive(1, 2, 32'hDEADBEEF, 0, 0, 0);
        chk("t1_count", count, 16'h0100);
        chk("t1_empty", empty, 4'b1011);
        push(2, 32'hDEADBEEF);
        drive(0, 0, 0, 1, 2, 0);
        chk("t1_rd", {credit_valid, credit_vc, rd_valid, rd_vc_out, rd_data},
                     {1'b1, 2'd2, 1'b1, 2'd2, 32'hDEADBEEF});
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_pulse", {credit_valid, rd_valid, rd_data}, {1'b0, 1'b0, 32'hDEADBEEF});
        chk("t1_cnt0", count, 16'h0);

        // T2: fill VC0, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'(100 + i), 0, 0, 0);
            chk("t2_af", almost_full[0], (i + 1) >= 6);
            chk("t2_full", full[0], i == 7);
        end
        drive(1, 0, 32'd999, 0, 0, 0);
        chk("t2_ovf", {overflow_err, cntv(0)}, {1'b1, 4'd8});
        for (int i = 0; i < 8; i++) begin
            push(0, 32'(100 + i));
            drive(0, 0, 0, 1, 0, 0);
        end
        chk("t2_drained", {empty[0], cntv(0)}, {1'b1, 4'd0});
        drive(0, 0, 0, 0, 0, 1);
        chk("t2_clr", overflow_err, 1'b0);

        // T3: interleaved VC1/VC3
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'hA0 + 32'(i), 0, 0, 0);
            drive(1, 3, 32'hB0 + 32'(i), 0, 0, 0);
        end
        chk("t3_cnt", {cntv(1), cntv(3)}, {4'd4, 4'd4});
        for (int i = 0; i < 4; i++) begin
            push(1, 32'hA0 + 32'(i));
            drive(0, 0, 0, 1, 1, 0);
            push(3, 32'hB0 + 32'(i));
            drive(0, 0, 0, 1, 3, 0);
            chk("t3_track", {cntv(1), cntv(3)}, {4'(3 - i), 4'(3 - i)});
        end

        // T4: simultaneous read/write on full VC0
        for (int i = 0; i < 8; i++) drive(1, 0, 32'(200 + i), 0, 0, 0);
        push(0, 32'd200);
        drive(1, 0, 32'hCAFEBABE, 1, 0, 0);
        chk("t4_rw", {overflow_err, full[0], cntv(0)}, {1'b0, 1'b1, 4'd8});
        for (int i = 1; i < 8; i++) push(0, 32'(200 + i));
        push(0, 32'hCAFEBABE);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, 0);
        chk("t4_empty", cntv(0), 4'd0);

        // T5: read-empty with same-VC write, error priority, clear
        drive(1, 3, 32'h55, 1, 3, 0);
        chk("t5_unf", {rd_valid, underflow_err, cntv(3)}, {1'b0, 1'b1, 4'd1});
        drive(0, 0, 0, 1, 2, 1);
        chk("t5_errwin", underflow_err, 1'b1);
        drive(0, 0, 0, 0, 0, 1);
        chk("t5_clr", {overflow_err, underflow_err}, 2'b00);
        push(3, 32'h55);
        drive(0, 0, 0, 1, 3, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_cnt3", cntv(3), 4'd0);

        // T6: async reset mid-burst
        for (int i = 0; i < 5; i++) drive(1, 1, 32'h10 + 32'(i), 0, 0, 0);
        chk("t6_cnt1", cntv(1), 4'd5);
        push(1, 32'h10);
        drive(1, 1, 32'h15, 1, 1, 0);
        chk("t6_pre", rd_valid, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async", {count, empty, rd_valid, credit_valid}, {16'h0, 4'hF, 1'b0, 1'b0});
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 1, 0);
        chk("t6_unf", {underflow_err, rd_valid}, {1'b1, 1'b0});

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nebula_vc_buffer.md
Name: nebula_vc_buffer

Overview:
Input buffer for a Nebula router port. It holds NUM_VCS independent virtual-channel FIFOs in one storage array, and each VC has its own pointers, count and flags. Every successful dequeue returns a one-cycle credit pulse tagged with the VC, which feeds upstream flow control. Illegal accesses (overflow or underflow) are dropped and recorded in sticky error flags.

Parameters:
DATA_WIDTH, 32, flit width in bits.
NUM_VCS, 4, number of virtual channels (must be >= 1).
DEPTH, 8, entries per VC (power of two, >= 2).
ALMOST_FULL_THRESH, DEPTH-2, almost_full[v] asserts when count_v >= this value.
ALMOST_EMPTY_THRESH, 2, almost_empty[v] asserts when count_v <= this value.
Derived values: VC_W = max(1, $clog2(NUM_VCS)); CNT_W = $clog2(DEPTH+1); PTR_W = $clog2(DEPTH).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write request.
wr_vc  in  VC_W  target VC of the write.
wr_data  in  DATA_WIDTH  flit to enqueue.
rd_en  in  1  read request.
rd_vc  in  VC_W  VC to dequeue.
rd_data  out  DATA_WIDTH  registered read data.
rd_valid  out  1  rd_data/rd_vc_out valid this cycle.
rd_vc_out  out  VC_W  VC that rd_data came from.
full  out  NUM_VCS  per-VC full.
almost_full  out  NUM_VCS  per-VC almost full.
empty  out  NUM_VCS  per-VC empty.
almost_empty  out  NUM_VCS  per-VC almost empty.
count  out  NUM_VCS*CNT_W  per-VC occupancy, VC v in bits [v*CNT_W +: CNT_W].
credit_valid  out  1  one-cycle pulse per accepted read.
credit_vc  out  VC_W  VC of the credit.
overflow_err  out  1  sticky: a write to a full VC was dropped.
underflow_err  out  1  sticky: a read of an empty VC was dropped.
err_clr  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All pointers and counts are 0.
  - empty = all 1s, almost_empty = all 1s, full = 0, almost_full = 0 (ALMOST_FULL_THRESH > 0 is required).
  - rd_valid = 0, rd_data = 0, rd_vc_out = 0, credit_valid = 0, credit_vc = 0, overflow_err = 0, underflow_err = 0.
- Reset asserted mid-operation discards all contents immediately. Storage RAM contents need not be cleared.
- Flags are combinational decodes of the count registers, so they reflect the edge on which the count changed: full[v] = (count_v == DEPTH), empty[v] = (count_v == 0).
- Write acceptance:
  - A write is accepted when wr_en=1 and count_wr_vc < DEPTH.
  - It is also accepted when the VC is full but a read of the same VC is accepted in the same cycle.
  - Otherwise the write is dropped, overflow_err is set, and no state changes.
- Read acceptance:
  - A read is accepted when rd_en=1 and count_rd_vc > 0, evaluated before any same-cycle write.
  - There is no bypass: a read of an empty VC with a simultaneous write to that VC is dropped, sets underflow_err, and the write is still accepted.
- Read latency is 1 cycle. The edge that accepts the read loads rd_data with the head entry and sets rd_valid=1, rd_vc_out=rd_vc, credit_valid=1, credit_vc=rd_vc.
- On the following cycle rd_valid and credit_valid return to 0 unless another read is accepted. rd_data holds its last value when rd_valid=0.
- Count update per VC: +1 for an accepted write only, -1 for an accepted read only, unchanged for both or neither.
- Writes and reads to different VCs in the same cycle are fully independent.
- Pointers wrap modulo DEPTH inside each VC's region; the physical address is vc*DEPTH + ptr.
- Out-of-range VC index (only possible when NUM_VCS is not a power of two): the request is dropped and sets the corresponding error flag (overflow_err for writes, underflow_err for reads).
- Sticky errors:
  - err_clr=1 clears both flags on the next edge.
  - If a new error and err_clr occur in the same cycle, the error wins (flag ends up 1).
- Data order is strict FIFO within each VC. There is no ordering relationship between VCs.

Test Plan:
1. Reset, then write 0xDEADBEEF to VC2 and read VC2 -> after the write edge count_2=1 and empty[2]=0 with other VCs unchanged; one cycle after the read rd_valid=1, rd_data=0xDEADBEEF, rd_vc_out=2, credit_valid=1 and credit_vc=2 for exactly one cycle.
2. Fill VC0 with 8 writes (100..107) -> full[0]=1 and almost_full[0]=1 from count 6; a 9th write sets overflow_err=1 and count_0 stays 8; draining yields 100..107 in order.
3. Interleave writes A0..A3 to VC1 and B0..B3 to VC3, then read alternately -> each VC returns its own order; counts track independently; credits are tagged 1,3,1,3,...
4. With VC0 full, write 0xCAFEBABE to VC0 and read VC0 in the same cycle -> both accepted, count stays 8, overflow_err stays 0, 0xCAFEBABE emerges last.
5. Read empty VC3 while writing 0x55 to VC3 -> rd_valid=0, underflow_err=1, count_3=1; then err_clr=1 -> both errors are 0 on the next cycle.
6. Assert rst_n=0 mid-burst with VC1 at count 5 -> all counts are 0, empty=all 1s and rd_valid=0 immediately (asynchronously); the first read after reset sets underflow_err.
